// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Operand-forwarding select for one E-stage source register.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rs_e_i,
    input  logic [REG_W-1:0] rd_m_i,
    input  logic [REG_W-1:0] rd_w_i,
    input  logic             reg_write_m_i,
    input  logic             reg_write_w_i,
    output logic [1:0]       fwd_o
);

    // M is younger than W, so its result wins; x0 is hardwired and never forwarded.
    always_comb begin
        // NOTE: assign a default first so every path drives fwd_o and no latch is inferred.
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline, with a memory-wait
// FSM, sticky timeout flag and saturating stall-cycle counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e           state_q;
    logic [7:0]       wait_cnt_q;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic       mem_stall;
    logic       lw_stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    fwd_unit u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    // The freeze is combinational so the very first miss cycle is already held.
    always_comb begin
        lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        case (state_q)
            RUN:      mem_stall = mem_req && !mem_ready;
            MEM_WAIT: mem_stall = !mem_ready;
            HALT:     mem_stall = 1'b1;
            default:  mem_stall = 1'b1;
        endcase
    end

    always_comb begin
        if (!rst_n) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else begin
            StallF    = mem_stall || lw_stall;
            StallD    = mem_stall || lw_stall;
            StallE    = mem_stall;
            StallM    = mem_stall;
            FlushD    = PCSrcE && !mem_stall;
            FlushE    = (lw_stall || PCSrcE) && !mem_stall;
            FlushW    = mem_stall;
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            stall_cnt_q <= stall_cnt_d;
            case (state_q)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q       <= HALT;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences, random vs model.
module tb_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, LoadE, PCSrcE, mem_req, mem_ready;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic mem_timeout;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .mem_req(mem_req), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
        mem_req = 0; mem_ready = 1;
    endtask

    // Reset pulse placed mid-cycle, away from the rising edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        cyc();
    endtask

    // ---------------- reference model ----------------
    bit m_halt, m_wait, m_to;
    int m_miss, m_cnt;

    task automatic model_reset();
        m_halt = 0; m_wait = 0; m_to = 0; m_miss = 0; m_cnt = 0;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_check_step(input string name);
        bit lw, ms, sf;
        logic [31:0] exp, act;
        lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        ms = m_halt || (!mem_ready && (m_wait || mem_req));
        sf = ms || lw;
        exp = {13'd0, sf, sf, ms, ms, PCSrcE && !ms, (lw || PCSrcE) && !ms, ms,
               ref_fwd(Rs1E), ref_fwd(Rs2E), m_to, 4'(m_cnt)};
        act = {13'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, mem_timeout, stall_cnt};
        check(name, act, exp);
        if (sf && m_cnt < CMAX) m_cnt++;
        if (!m_halt) begin
            if (ms) begin
                m_miss++;
                m_wait = 1;
                if (m_miss > TO) begin m_halt = 1; m_to = 1; end
            end else begin
                m_wait = 0;
                m_miss = 0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic rwm, rww, loade, pcsrc;
        logic sf, fd, fe;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int exp_cnt;
        rst_n = 1'b0;
        set_idle();
        #2;
        check("reset_flushes", {29'd0, FlushD, FlushE, FlushW}, 32'h7);
        check("reset_stalls", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
        check("reset_fwd", {28'd0, ForwardAE, ForwardBE}, 32'h0);
        check("reset_regs", {27'd0, mem_timeout, stall_cnt}, 32'h0);
        #3 rst_n = 1'b1;
        cyc();

        //            rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld br  sf fd fe fa     fb
        vecs[0] = '{5,  3,   1,   2,   5,  0,  0,  0,  0,  1, 0,  1, 0, 1, 2'b00, 2'b00};
        vecs[1] = '{0,  0,   1,   2,   0,  0,  0,  0,  0,  1, 0,  0, 0, 0, 2'b00, 2'b00};
        vecs[2] = '{0,  0,   1,   7,   0,  7,  7,  1,  1,  0, 0,  0, 0, 0, 2'b00, 2'b10};
        vecs[3] = '{0,  0,   1,   7,   0,  7,  7,  0,  1,  0, 0,  0, 0, 0, 2'b00, 2'b01};
        vecs[4] = '{0,  0,   0,   0,   0,  0,  0,  1,  1,  0, 0,  0, 0, 0, 2'b00, 2'b00};
        vecs[5] = '{0,  0,   9,   9,   0,  9,  9,  1,  1,  0, 0,  0, 0, 0, 2'b10, 2'b10};
        vecs[6] = '{0,  0,   1,   2,   0,  0,  0,  0,  0,  0, 1,  0, 1, 1, 2'b00, 2'b00};
        vecs[7] = '{1,  4,   1,   2,   4,  0,  0,  0,  0,  1, 1,  1, 1, 1, 2'b00, 2'b00};
        vecs[8] = '{0,  0,   12,  3,   0,  13, 12, 1,  1,  0, 0,  0, 0, 0, 2'b01, 2'b00};

        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            LoadE = vecs[i].loade; PCSrcE = vecs[i].pcsrc;
            #1;
            check($sformatf("vec%0d_ctl", i),
                  {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
                  {25'd0, vecs[i].sf, vecs[i].sf, 2'b00, vecs[i].fd, vecs[i].fe, 1'b0});
            check($sformatf("vec%0d_fwd", i), {28'd0, ForwardAE, ForwardBE},
                  {28'd0, vecs[i].fa, vecs[i].fb});
            check($sformatf("vec%0d_cnt", i), {28'd0, stall_cnt}, 32'(exp_cnt));
            if (vecs[i].sf) exp_cnt++;
            cyc();
        end
        set_idle();

        // Memory wait: three unready cycles, then completion.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wait%0d_stall", i), {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
            check($sformatf("wait%0d_flushw", i), {31'd0, FlushW}, 32'h1);
            cyc();
        end
        mem_ready = 1;
        #1;
        check("wait_release", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'h0);
        cyc();
        mem_req = 0;
        #1;
        check("wait_cnt3", {28'd0, stall_cnt}, 32'd3);
        check("wait_back_run", {31'd0, StallF}, 32'd0);

        // Branch held in E while the memory stalls.
        do_reset();
        mem_req = 1; mem_ready = 0; PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("brwait%0d_noflush", i), {30'd0, FlushD, FlushE}, 32'h0);
            cyc();
        end
        mem_ready = 1;
        #1;
        check("brwait_release_flush", {30'd0, FlushD, FlushE}, 32'h3);
        cyc();
        set_idle();

        // Timeout: memory never answers.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i <= TO; i++) begin
            #1;
            check($sformatf("to%0d_flag_low", i), {30'd0, mem_timeout, StallF}, 32'h1);
            cyc();
        end
        #1;
        check("to_flag_set", {31'd0, mem_timeout}, 32'h1);
        mem_req = 0; mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("halt%0d_stalls", i), {28'd0, StallF, StallE, FlushW, mem_timeout}, 32'hF);
        end
        #1 rst_n = 1'b0;
        #1;
        check("to_async_clear", {26'd0, mem_timeout, stall_cnt, StallF, FlushD}, 32'h1);
        #2 rst_n = 1'b1;
        #1;
        check("to_after_reset_run", {30'd0, StallF, mem_timeout}, 32'h0);
        cyc();

        // Reset mid-MEM_WAIT returns to RUN immediately.
        mem_req = 1; mem_ready = 0;
        cyc(); cyc();
        #1 rst_n = 1'b0;
        #1;
        check("midwait_reset_cnt", {28'd0, stall_cnt}, 32'd0);
        #1 rst_n = 1'b1;
        mem_ready = 1;
        #1;
        check("midwait_run", {30'd0, StallF, StallE}, 32'h0);
        cyc();
        set_idle();

        // Saturation of the stall counter under a held load-use stall.
        do_reset();
        LoadE = 1; RdE = 5; Rs1D = 5;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("sat%0d", i), {28'd0, stall_cnt}, 32'((i < CMAX) ? i : CMAX));
            cyc();
        end
        set_idle();

        // Randomized traffic against the behavioural model.
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            LoadE = 1'($urandom); PCSrcE = ($urandom_range(0, 3) == 0);
            mem_req = 1'($urandom); mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_check_step($sformatf("rand%0d", n));
            cyc();
            if (m_halt && $urandom_range(0, 3) == 0) begin
                do_reset();
                model_reset();
            end else if (n % 50 == 49) begin
                do_reset();
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
